// File: rtl/mux_nt1_reg_pkg.sv
// Shared constants and helpers for the N:1 registered selector.
package mux_nt1_reg_pkg;

    localparam int MUX_MAX_NIN = 16;

    // Select width for n inputs; a 1-input mux still gets a 1-bit select.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_nt1_reg_if.sv
// Data/handshake bundle between the selector stage and its producer/consumer.
interface mux_nt1_reg_if #(
    parameter int WIDTH = 32,
    parameter int NIN   = 4
);
    import mux_nt1_reg_pkg::*;

    localparam int SELW = sel_w(NIN);

    logic [NIN*WIDTH-1:0] in_bus;
    logic [SELW-1:0]      sel;
    logic                 sel_we;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     o;
    logic                 o_valid;
    logic                 o_ready;
    logic [SELW-1:0]      sel_q;
    logic                 err;
    logic                 err_clr;

    modport master (
        output in_bus, sel, sel_we, in_valid, o_ready, err_clr,
        input  in_ready, o, o_valid, sel_q, err
    );

    modport slave (
        input  in_bus, sel, sel_we, in_valid, o_ready, err_clr,
        output in_ready, o, o_valid, sel_q, err
    );

endinterface

// File: rtl/mux_nt1_reg_comb.sv
// Combinational indexed select; oob flags a select with no matching input.
module mux_nt1_comb
    import mux_nt1_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NIN   = 4,
    localparam int SELW = sel_w(NIN)
) (
    input  logic [NIN*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     data,
    output logic                 oob
);

    always_comb begin
        data = '0;
        oob  = 1'b1;
        for (int k = 0; k < NIN; k++) begin
            if (int'(sel) == k) begin
                data = in_bus[k*WIDTH +: WIDTH];
                oob  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_nt1_reg.sv
// N:1 selector with latched select, one-deep valid/ready output register and sticky range error.
module mux_nt1_reg
    import mux_nt1_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               NIN       = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic          clk,
    input logic          rst,
    mux_nt1_reg_if.slave bus
);

    localparam int SELW = sel_w(NIN);

    if (NIN < 2 || NIN > MUX_MAX_NIN) begin : g_bad_nin
        $error("mux_nt1_reg: NIN out of range 2..16");
    end

    logic [SELW-1:0]  sel_d, sel_q;
    logic [WIDTH-1:0] o_d, o_q;
    logic             o_valid_d, o_valid_q;
    logic             err_d, err_q;

    logic [SELW-1:0]  eff_sel;
    logic [WIDTH-1:0] mux_data;
    logic             mux_oob;
    logic             in_ready;
    logic             accept;

    // A same-cycle select load steers the same-cycle transfer.
    assign eff_sel  = bus.sel_we ? bus.sel : sel_q;
    assign in_ready = !o_valid_q | bus.o_ready;
    assign accept   = bus.in_valid & in_ready;

    mux_nt1_comb #(.WIDTH(WIDTH), .NIN(NIN)) u_comb (
        .in_bus (bus.in_bus),
        .sel    (eff_sel),
        .data   (mux_data),
        .oob    (mux_oob)
    );

    always_comb begin
        sel_d     = bus.sel_we ? bus.sel : sel_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;
        err_d     = err_q;
        if (accept) begin
            o_d       = mux_oob ? RESET_VAL : mux_data;
            o_valid_d = 1'b1;
        end else if (bus.o_ready) begin
            o_valid_d = 1'b0;
        end
        // Setting beats clearing when both happen in one cycle.
        if (bus.err_clr)
            err_d = 1'b0;
        if (accept && mux_oob)
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            o_q       <= RESET_VAL;
            o_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.o        = o_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.sel_q    = sel_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mux_nt1_reg.sv
// Drives a 4-input and a 3-input selector with identical stimulus against a behavioural model.
module tb_mux_nt1_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  sel;
    logic        sel_we, in_valid, o_ready, err_clr;
    logic [31:0] in_vals [4];

    mux_nt1_reg_if #(.WIDTH(32), .NIN(4)) if4 ();
    mux_nt1_reg_if #(.WIDTH(32), .NIN(3)) if3 ();

    mux_nt1_reg #(.WIDTH(32), .NIN(4), .RESET_VAL(32'h0)) u_dut4 (
        .clk (clk), .rst (rst), .bus (if4)
    );
    mux_nt1_reg #(.WIDTH(32), .NIN(3), .RESET_VAL(32'hDEAD_BEEF)) u_dut3 (
        .clk (clk), .rst (rst), .bus (if3)
    );

    assign if4.in_bus   = {in_vals[3], in_vals[2], in_vals[1], in_vals[0]};
    assign if3.in_bus   = {in_vals[2], in_vals[1], in_vals[0]};
    assign if4.sel      = sel;
    assign if3.sel      = sel;
    assign if4.sel_we   = sel_we;
    assign if3.sel_we   = sel_we;
    assign if4.in_valid = in_valid;
    assign if3.in_valid = in_valid;
    assign if4.o_ready  = o_ready;
    assign if3.o_ready  = o_ready;
    assign if4.err_clr  = err_clr;
    assign if3.err_clr  = err_clr;

    logic [31:0] obs_o   [2];
    logic        obs_v   [2];
    logic [1:0]  obs_sel [2];
    logic        obs_err [2];
    logic        obs_rdy [2];
    assign obs_o[0]   = if4.o;        assign obs_o[1]   = if3.o;
    assign obs_v[0]   = if4.o_valid;  assign obs_v[1]   = if3.o_valid;
    assign obs_sel[0] = if4.sel_q;    assign obs_sel[1] = if3.sel_q;
    assign obs_err[0] = if4.err;      assign obs_err[1] = if3.err;
    assign obs_rdy[0] = if4.in_ready; assign obs_rdy[1] = if3.in_ready;

    // Reference state: the word the consumer would see, whether one is pending, latched select, error.
    logic [31:0] m_o   [2];
    logic        m_v   [2];
    logic [1:0]  m_sel [2];
    logic        m_err [2];

    int vec  = 0;
    int miss = 0;

    function automatic int nin_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] rv_of(input int d);
        return (d == 0) ? 32'h0 : 32'hDEAD_BEEF;
    endfunction

    // Advance the reference by one clock using the current stimulus, then step the DUTs.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            int  es;
            bit  take;
            bit  bad;
            if (rst) begin
                m_o[d] = rv_of(d); m_v[d] = 1'b0; m_sel[d] = 2'd0; m_err[d] = 1'b0;
            end else begin
                es   = sel_we ? int'(sel) : int'(m_sel[d]);
                take = in_valid && (!m_v[d] || o_ready);
                bad  = take && (es >= nin_of(d));
                if (take) begin
                    m_o[d] = bad ? rv_of(d) : in_vals[es];
                    m_v[d] = 1'b1;
                end else if (m_v[d] && o_ready) begin
                    m_v[d] = 1'b0;
                end
                m_err[d] = bad ? 1'b1 : (err_clr ? 1'b0 : m_err[d]);
                if (sel_we) m_sel[d] = sel;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [1:0] s, input logic we,
                         input logic iv, input logic ordy, input logic ec);
        rst = r; sel = s; sel_we = we; in_valid = iv; o_ready = ordy; err_clr = ec;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) in_vals[k] = 32'h5555_0000 + k;
        drive(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        vec++;
        if ({if4.o, if4.o_valid, if4.sel_q, if4.err} !== {32'h0, 1'b0, 2'd0, 1'b0}) begin
            miss++;
            $display("FAIL reset4: got o=%h v=%b sel_q=%0d err=%b, want o=0 v=0 sel_q=0 err=0",
                     if4.o, if4.o_valid, if4.sel_q, if4.err);
        end
        vec++;
        if ({if3.o, if3.o_valid, if3.sel_q, if3.err} !== {32'hDEAD_BEEF, 1'b0, 2'd0, 1'b0}) begin
            miss++;
            $display("FAIL reset3: got o=%h v=%b sel_q=%0d err=%b, want o=deadbeef v=0 sel_q=0 err=0",
                     if3.o, if3.o_valid, if3.sel_q, if3.err);
        end
    endtask

    task automatic test_write_through();
        for (int k = 0; k < 4; k++) in_vals[k] = 32'hA0 + k;
        drive(1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        vec++;
        if ({if4.o, if4.o_valid, if4.sel_q} !== {32'hA2, 1'b1, 2'd2}) begin
            miss++;
            $display("FAIL write_through: got o=%h v=%b sel_q=%0d, want o=a2 v=1 sel_q=2",
                     if4.o, if4.o_valid, if4.sel_q);
        end
    endtask

    task automatic test_backpressure();
        in_vals[2] = 32'hFF;
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            vec++;
            if (if4.in_ready !== 1'b0) begin
                miss++;
                $display("FAIL stall_ready c%0d: got in_ready=%b, want 0", c, if4.in_ready);
            end
            tick();
            vec++;
            if ({if4.o, if4.o_valid} !== {32'hA2, 1'b1}) begin
                miss++;
                $display("FAIL stall_hold c%0d: got o=%h v=%b, want o=a2 v=1", c, if4.o, if4.o_valid);
            end
        end
        o_ready = 1'b1;
        tick();
        vec++;
        if ({if4.o, if4.o_valid} !== {32'hFF, 1'b1}) begin
            miss++;
            $display("FAIL stall_release: got o=%h v=%b, want o=ff v=1", if4.o, if4.o_valid);
        end
    endtask

    task automatic test_stream();
        drive(1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        // Select bus now carries a different value that must be ignored without sel_we.
        drive(1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            in_vals[1] = i;
            tick();
            for (int d = 0; d < 2; d++) begin
                vec++;
                if ({obs_o[d], obs_v[d], obs_sel[d]} !== {i[31:0], 1'b1, 2'd1}) begin
                    miss++;
                    $display("FAIL stream d%0d i%0d: got o=%h v=%b sel_q=%0d, want o=%h v=1 sel_q=1",
                             d, i, obs_o[d], obs_v[d], obs_sel[d], i);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        in_vals[3] = 32'h0333_0333;
        drive(1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        vec++;
        if ({if3.o, if3.o_valid, if3.err} !== {32'hDEAD_BEEF, 1'b1, 1'b1}) begin
            miss++;
            $display("FAIL oob_accept: got o=%h v=%b err=%b, want o=deadbeef v=1 err=1",
                     if3.o, if3.o_valid, if3.err);
        end
        vec++;
        if ({if4.o, if4.err} !== {32'h0333_0333, 1'b0}) begin
            miss++;
            $display("FAIL inrange_sel3: got o=%h err=%b, want o=03330333 err=0", if4.o, if4.err);
        end
        drive(1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        vec++;
        if (if3.err !== 1'b1) begin
            miss++;
            $display("FAIL set_beats_clear: got err=%b, want 1", if3.err);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        vec++;
        if (if3.err !== 1'b0) begin
            miss++;
            $display("FAIL err_clr: got err=%b, want 0", if3.err);
        end
        // sel_q still out of range, but nothing is accepted.
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        vec++;
        if ({if3.err, if3.sel_q, if3.o_valid} !== {1'b0, 2'd3, 1'b0}) begin
            miss++;
            $display("FAIL idle_oob: got err=%b sel_q=%0d v=%b, want err=0 sel_q=3 v=0",
                     if3.err, if3.sel_q, if3.o_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            vec++;
            if ({if4.o_valid, if3.o_valid, if4.o, if3.o} !== {1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF}) begin
                miss++;
                $display("FAIL reset_mid c%0d: got v4=%b v3=%b o4=%h o3=%h, want 0 0 0 deadbeef",
                         c, if4.o_valid, if3.o_valid, if4.o, if3.o);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 4; k++) in_vals[k] = $urandom;
            drive(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
            #1;
            for (int d = 0; d < 2; d++) begin
                vec++;
                if (obs_rdy[d] !== (!m_v[d] || o_ready)) begin
                    miss++;
                    $display("FAIL rand_ready d%0d n%0d: got %b, want %b",
                             d, n, obs_rdy[d], (!m_v[d] || o_ready));
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                vec++;
                if ({obs_o[d], obs_v[d], obs_sel[d], obs_err[d]} !== {m_o[d], m_v[d], m_sel[d], m_err[d]}) begin
                    miss++;
                    $display("FAIL rand_state d%0d n%0d: got o=%h v=%b sel_q=%0d err=%b, want o=%h v=%b sel_q=%0d err=%b",
                             d, n, obs_o[d], obs_v[d], obs_sel[d], obs_err[d],
                             m_o[d], m_v[d], m_sel[d], m_err[d]);
                end
            end
        end
    endtask

    initial begin
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) in_vals[k] = '0;
        test_reset();
        test_write_through();
        test_backpressure();
        test_stream();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
